// File: rtl/cache_arb_pkg.sv
// Shared types for the cache bus arbiter.
// State encoding, default widths and index-width helper.
package cache_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RDATA,
    WDATA,
    WRESP
  } arb_state_e;

  localparam int DEF_PORT_NUM = 2;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LEN_W    = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_rr_pick.sv
// Combinational picker: first valid bit searching upward
// from ptr, wrapping at N. ptr tied to 0 gives fixed priority.
module rr_pick
  import cache_arb_pkg::*;
#(
  parameter int N  = DEF_PORT_NUM,
  parameter int IW = idx_w(DEF_PORT_NUM)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan downward so the nearest candidate to ptr wins last.
  always_comb begin
    int c;
    c     = 0;
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (valid[c]) begin
        idx   = IW'(c);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// N-to-1 cache bus arbiter holding the grant for a whole transaction.
// Define CACHE_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int PORT_NUM = DEF_PORT_NUM,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORT_NUM-1:0]        s_req_valid,
  output logic [PORT_NUM-1:0]        s_req_ready,
  input  logic [PORT_NUM-1:0]        s_req_write,
  input  logic [PORT_NUM*ADDR_W-1:0] s_req_addr,
  input  logic [PORT_NUM*LEN_W-1:0]  s_req_len,
  input  logic [PORT_NUM-1:0]        s_wvalid,
  output logic [PORT_NUM-1:0]        s_wready,
  input  logic [PORT_NUM*DATA_W-1:0] s_wdata,
  input  logic [PORT_NUM-1:0]        s_wlast,
  output logic [PORT_NUM-1:0]        s_rvalid,
  output logic [DATA_W-1:0]          s_rdata,
  output logic                       s_rlast,
  output logic [PORT_NUM-1:0]        s_bvalid,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic                       m_req_write,
  output logic [ADDR_W-1:0]          m_req_addr,
  output logic [LEN_W-1:0]           m_req_len,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic                       m_wlast,
  input  logic                       m_rvalid,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_rlast,
  input  logic                       m_bvalid
);

  localparam int IW = idx_w(PORT_NUM);

  arb_state_e    state;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr;
  logic [IW-1:0] g_nxt;
  logic [IW-1:0] pick;
  logic          found;
  logic          tx_done;

  rr_pick #(
    .N  (PORT_NUM),
    .IW (IW)
  ) u_pick (
    .valid (s_req_valid),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

  // Explicit compare so non-power-of-2 port counts wrap correctly.
  assign g_nxt = (g == IW'(PORT_NUM - 1)) ? '0 : g + 1'b1;

  assign tx_done = (state == RDATA && m_rvalid && m_rlast) ||
                   (state == WRESP && m_bvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            g     <= pick;
            state <= REQ;
          end
        end
        REQ: begin
          if (m_req_ready)
            state <= s_req_write[g] ? WDATA : RDATA;
        end
        RDATA: begin
          if (m_rvalid && m_rlast) state <= IDLE;
        end
        WDATA: begin
          if (m_wvalid && m_wready && m_wlast)
            state <= WRESP;
        end
        WRESP: begin
          if (m_bvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CACHE_ARB_FIXED_PRIO_EN
      ptr <= '0;
`else
      if (tx_done) ptr <= g_nxt;
`endif
    end
  end

  always_comb begin
    s_req_ready = '0;
    s_wready    = '0;
    s_rvalid    = '0;
    s_bvalid    = '0;
    s_rdata     = '0;
    s_rlast     = 1'b0;
    m_req_valid = 1'b0;
    m_req_write = 1'b0;
    m_req_addr  = '0;
    m_req_len   = '0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wlast     = 1'b0;
    unique case (state)
      REQ: begin
        m_req_valid    = 1'b1;
        m_req_write    = s_req_write[g];
        m_req_addr     = s_req_addr[g*ADDR_W +: ADDR_W];
        m_req_len      = s_req_len[g*LEN_W +: LEN_W];
        s_req_ready[g] = m_req_ready;
      end
      RDATA: begin
        s_rvalid[g] = m_rvalid;
        s_rdata     = m_rdata;
        s_rlast     = m_rlast;
      end
      WDATA: begin
        m_wvalid    = s_wvalid[g];
        m_wdata     = s_wdata[g*DATA_W +: DATA_W];
        m_wlast     = s_wlast[g];
        s_wready[g] = m_wready;
      end
      WRESP: s_bvalid[g] = m_bvalid;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (state == REQ) |-> s_req_valid[g])
    else $error("requester withdrew before accept");

  a_stray_r: assert property (@(posedge clk) disable iff (rst)
    m_rvalid |-> (state == RDATA))
    else $warning("m_rvalid outside RDATA ignored");

  a_stray_b: assert property (@(posedge clk) disable iff (rst)
    m_bvalid |-> (state == WRESP))
    else $warning("m_bvalid outside WRESP ignored");
`endif

endmodule
